// File: rtl/p_bank_ctrl.sv
// Command sequencer for a bank of asynchronous P state cells: turns WRITE/READ/RESET/SETIN
// requests into timed setup/enable/hold pulses and returns synchronized cell outputs.
module p_bank_ctrl #(
    parameter int NUM_CELLS = 8,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 1,
    parameter int HOLD_CYC  = 2,
    parameter int RST_CYC   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [NUM_CELLS-1:0] req_mask,
    input  logic [NUM_CELLS-1:0] req_data,
    output logic                 done,
    output logic [NUM_CELLS-1:0] rsp_data,
    output logic                 p_rst,
    output logic [NUM_CELLS-1:0] p_en,
    output logic [NUM_CELLS-1:0] p_fb,
    output logic [NUM_CELLS-1:0] p_in,
    input  logic [NUM_CELLS-1:0] p_out
);

    localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_B   = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_N = CW'(SETUP_CYC);
    localparam logic [CW-1:0] EN_N    = CW'(EN_CYC);
    localparam logic [CW-1:0] HOLD_N  = CW'(HOLD_CYC);
    localparam logic [CW-1:0] RST_N   = CW'(RST_CYC);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_RESET = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_SETIN = 2'b11;

    typedef enum logic [2:0] {
        INIT_RST,
        IDLE,
        SETUP,
        ENABLE,
        RST_PH,
        HOLD,
        DONE_ST
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [NUM_CELLS-1:0]   en_mask;
    logic [NUM_CELLS-1:0]   sync_p0;
    logic                   accept;
    logic                   hold_last;

    assign accept    = req_valid && req_ready;
    assign hold_last = (state == HOLD) && (cnt == HOLD_N);

    // Every timed phase is entered with cnt=1 and left when cnt reaches its length.
    // Reset parks cnt at 0 so the release edge itself counts as the first init cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        case (state)
            INIT_RST: begin
                if (cnt == RST_N) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            IDLE: begin
                cnt_n = CNT_ONE;
                if (accept) begin
                    case (req_op)
                        OP_WRITE: state_n = SETUP;
                        OP_RESET: state_n = RST_PH;
                        default:  state_n = HOLD;
                    endcase
                end
            end
            SETUP: begin
                if (cnt == SETUP_N) begin
                    state_n = ENABLE;
                    cnt_n   = CNT_ONE;
                end
            end
            ENABLE: begin
                if (cnt == EN_N) begin
                    state_n = HOLD;
                    cnt_n   = CNT_ONE;
                end
            end
            RST_PH: begin
                if (cnt == RST_N) begin
                    state_n = HOLD;
                    cnt_n   = CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt == HOLD_N) begin
                    state_n = DONE_ST;
                    cnt_n   = '0;
                end
            end
            DONE_ST: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = INIT_RST;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT_RST;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Outputs are decoded from the next state so every cell control line is a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_rst     <= 1'b1;
            p_en      <= '0;
            p_fb      <= '0;
            p_in      <= '0;
            req_ready <= 1'b0;
            done      <= 1'b0;
            rsp_data  <= '0;
            sync_p0   <= '0;
        end else begin
            p_rst     <= (state_n == INIT_RST) || (state_n == RST_PH);
            p_en      <= (state_n == ENABLE) ? en_mask : '0;
            req_ready <= (state_n == IDLE);
            done      <= (state_n == DONE_ST);
            sync_p0   <= p_out;
            if (accept && (req_op == OP_WRITE))
                p_fb <= req_data;
            if (accept && (req_op == OP_SETIN))
                p_in <= req_data;
            // rsp_data is the second synchronizer flop on this edge, so a cell change
            // launched at accept time is already visible after a two-cycle hold.
            if (hold_last)
                rsp_data <= sync_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (req_op == OP_WRITE))
            en_mask <= req_mask;
    end

endmodule

// File: tb/tb_p_bank_ctrl.sv
// Directed bench for p_bank_ctrl: eight behavioural P cells (INIT=0) on the cell bus,
// a table of commands with hand-computed results, and sequences for reset and back-pressure.
module tb_p_bank_ctrl;

    localparam int N = 8;
    localparam logic [N-1:0] CELL_INIT = 8'h00;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [N-1:0] req_mask;
    logic [N-1:0] req_data;
    logic         done;
    logic [N-1:0] rsp_data;
    logic         p_rst;
    logic [N-1:0] p_en;
    logic [N-1:0] p_fb;
    logic [N-1:0] p_in;
    logic [N-1:0] p_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    p_bank_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_mask  (req_mask),
        .req_data  (req_data),
        .done      (done),
        .rsp_data  (rsp_data),
        .p_rst     (p_rst),
        .p_en      (p_en),
        .p_fb      (p_fb),
        .p_in      (p_in),
        .p_out     (p_out)
    );

    // Asynchronous P cells: rst forces state to INIT^in, en loads in^fb, otherwise hold.
    logic [N-1:0] cell_state = '0;
    always @(p_rst or p_en or p_fb or p_in) begin
        for (int i = 0; i < N; i++) begin
            if (p_rst)
                cell_state[i] = CELL_INIT[i] ^ p_in[i];
            else if (p_en[i])
                cell_state[i] = p_in[i] ^ p_fb[i];
        end
    end
    assign p_out = cell_state ^ p_in;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] mask;
        logic [N-1:0] data;
        int           lat;
        logic [N-1:0] rsp;
        logic [N-1:0] en_val;
        int           en_cyc;
        int           rst_cyc;
        logic [N-1:0] fb;
        logic [N-1:0] in_v;
    } vec_t;

    vec_t vecs[8];
    vec_t v_write_ff;
    vec_t v_post_rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        check({tag, " ready"}, req_ready, 1);
    endtask

    task automatic issue(input vec_t v);
        req_valid = 1'b1;
        req_op    = v.op;
        req_mask  = v.mask;
        req_data  = v.data;
        tick();
        req_valid = 1'b0;
    endtask

    // Cycle n=1 is the first cycle after the accept edge.
    task automatic run_cmd(input vec_t v, input string tag);
        int n, en_cyc, en_cnt, rst_cnt, overlap;
        logic [N-1:0] en_val;
        wait_ready(tag);
        issue(v);
        n = 1; en_cyc = 0; en_cnt = 0; rst_cnt = 0; overlap = 0; en_val = '0;
        while (1) begin
            if (p_en != '0) begin
                en_cnt++;
                if (en_cyc == 0) begin
                    en_cyc = n;
                    en_val = p_en;
                end
            end
            if (p_rst) rst_cnt++;
            if (p_rst && p_en != '0) overlap++;
            if (done || n >= 20) break;
            tick();
            n++;
        end
        check({tag, " done latency"}, n, v.lat);
        check({tag, " rsp_data"}, rsp_data, v.rsp);
        check({tag, " en cycle"}, en_cyc, v.en_cyc);
        check({tag, " en value"}, en_val, v.en_val);
        check({tag, " en count"}, en_cnt, (v.en_cyc != 0) ? 1 : 0);
        check({tag, " rst cycles"}, rst_cnt, v.rst_cyc);
        check({tag, " rst/en overlap"}, overlap, 0);
        check({tag, " p_fb"}, p_fb, v.fb);
        check({tag, " p_in"}, p_in, v.in_v);
        tick();
        check({tag, " ready after done"}, req_ready, 1);
        check({tag, " done one cycle"}, done, 0);
    endtask

    task automatic init_count(input string tag);
        int w, rcnt, dcnt;
        w = 0; rcnt = 0; dcnt = 0;
        while (!req_ready && w < 30) begin
            tick();
            w++;
            if (p_rst) rcnt++;
            if (done) dcnt++;
        end
        check({tag, " init p_rst cycles"}, rcnt, 4);
        check({tag, " init done"}, dcnt, 0);
        check({tag, " init ready"}, req_ready, 1);
        check({tag, " init p_rst low"}, p_rst, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy, dn;
        //             op     mask   data   lat rsp    en_val en_c rst fb     in
        vecs[0] = '{2'b00, 8'h0F, 8'hA5, 6, 8'h05, 8'h0F, 3, 0, 8'hA5, 8'h00};
        vecs[1] = '{2'b10, 8'h00, 8'h00, 3, 8'h05, 8'h00, 0, 0, 8'hA5, 8'h00};
        vecs[2] = '{2'b11, 8'h00, 8'hFF, 3, 8'hFA, 8'h00, 0, 0, 8'hA5, 8'hFF};
        vecs[3] = '{2'b01, 8'h00, 8'h00, 7, 8'h00, 8'h00, 0, 4, 8'hA5, 8'hFF};
        vecs[4] = '{2'b11, 8'h00, 8'h00, 3, 8'hFF, 8'h00, 0, 0, 8'hA5, 8'h00};
        vecs[5] = '{2'b00, 8'h00, 8'hFF, 6, 8'hFF, 8'h00, 0, 0, 8'hFF, 8'h00};
        vecs[6] = '{2'b00, 8'hF0, 8'h3C, 6, 8'h3F, 8'hF0, 3, 0, 8'h3C, 8'h00};
        vecs[7] = '{2'b10, 8'h00, 8'h00, 3, 8'h3F, 8'h00, 0, 0, 8'h3C, 8'h00};
        v_write_ff = '{2'b00, 8'hFF, 8'h00, 6, 8'h00, 8'hFF, 3, 0, 8'h00, 8'h00};
        v_post_rst = '{2'b10, 8'h00, 8'h00, 3, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00};

        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_mask = '0; req_data = '0;

        // Power-up
        tick(); tick(); tick();
        check("reset p_rst", p_rst, 1);
        check("reset req_ready", req_ready, 0);
        check("reset done", done, 0);
        check("reset p_en", p_en, 0);
        check("reset p_fb", p_fb, 0);
        check("reset p_in", p_in, 0);
        check("reset rsp_data", rsp_data, 0);
        rst_n = 1'b1;
        init_count("powerup");

        for (int i = 0; i < 8; i++)
            run_cmd(vecs[i], $sformatf("vec%0d", i));

        // req_valid held high across busy cycles: one READ accepted per IDLE cycle
        wait_ready("busy");
        req_valid = 1'b1; req_op = 2'b10; req_mask = '0; req_data = '0;
        rdy = 0; dn = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (req_ready) rdy++;
            if (done) begin
                dn++;
                check("busy rsp_data", rsp_data, 8'h3F);
            end
        end
        req_valid = 1'b0;
        check("busy ready cycles", rdy, 4);
        check("busy done pulses", dn, 4);
        tick(); tick(); tick();
        check("busy idle after drop", req_ready, 1);
        check("busy no extra done", done, 0);

        // Reset dropped during the ENABLE cycle of a WRITE
        wait_ready("abort");
        issue(v_write_ff);
        tick(); tick();
        check("abort p_en in enable", p_en, 8'hFF);
        rst_n = 1'b0;
        tick();
        check("abort p_en dropped", p_en, 0);
        check("abort p_rst", p_rst, 1);
        check("abort done", done, 0);
        check("abort ready", req_ready, 0);
        check("abort rsp_data", rsp_data, 0);
        check("abort p_fb", p_fb, 0);
        rst_n = 1'b1;
        init_count("abort");
        run_cmd(v_post_rst, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/p_bank_ctrl.md
Name: p_bank_ctrl

Overview:
- Clocked sequencer that drives a bank of NUM_CELLS asynchronous P state cells.
- A P cell has inputs rst, en, fb and in, and output out; out = state ^ in. While en is high, state = in ^ fb, so out follows fb. While rst is high, state = INIT ^ in, so out = INIT.
- This block accepts WRITE/READ/RESET/SETIN commands on a valid/ready interface and turns each into a timed setup/enable/hold pulse sequence on the cell control lines.
- It samples the cell outputs through a synchronizer and returns them with a done pulse. It sits between the synchronous command domain and the async P-cell array.

Parameters:
- NUM_CELLS, 8, number of 1-bit P cells controlled (>=1).
- SETUP_CYC, 2, cycles p_fb is stable before p_en rises (>=1).
- EN_CYC, 1, cycles p_en is held high (>=1).
- HOLD_CYC, 2, cycles after p_en/p_rst/p_in change before sampling (>=2; covers the synchronizer).
- RST_CYC, 4, cycles p_rst is held high per RESET operation and at power-up (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  00 WRITE, 01 RESET, 10 READ, 11 SETIN.
- req_mask  in  NUM_CELLS  WRITE: cells to enable.
- req_data  in  NUM_CELLS  WRITE: fb values; SETIN: new in values.
- done  out  1  one-cycle pulse, operation complete.
- rsp_data  out  NUM_CELLS  synchronized p_out captured at end of HOLD; valid with done, held until next done.
- p_rst  out  1  to all cells' rst.
- p_en  out  NUM_CELLS  per-cell en.
- p_fb  out  NUM_CELLS  per-cell fb.
- p_in  out  NUM_CELLS  per-cell in.
- p_out  in  NUM_CELLS  cell outputs (asynchronous; two-flop synchronized internally).

Behaviour:
- Reset (rst_n=0 at an edge): state=INIT_RST, p_rst=1, p_en=0, p_fb=0, p_in=0, req_ready=0, done=0, rsp_data=0, synchronizer flops=0. All outputs are registered.
- Reset mid-operation aborts immediately: p_en drops at that edge; no done is issued.
- INIT_RST (power-up): p_rst=1 for RST_CYC cycles counted from the first edge with rst_n=1, then IDLE. No done is issued.
- IDLE: req_ready=1, all p_en=0, p_rst=0. Accept occurs on req_valid&&req_ready at edge k; command fields are registered at k. req_valid without ready is ignored; no queuing.
- WRITE: at k, p_fb<=req_data and mask is registered.
  - SETUP for cycles k+1..k+SETUP_CYC.
  - ENABLE for EN_CYC cycles: p_en = mask.
  - HOLD for HOLD_CYC cycles: p_en=0.
  - DONE.
  - Defaults: p_en high in cycle k+3, done in cycle k+6, req_ready back in k+7.
- READ: HOLD for HOLD_CYC cycles, then DONE. Defaults: done at k+3.
- RESET: p_rst=1 for RST_CYC cycles, then HOLD, then DONE. Defaults: done at k+7.
- SETIN: p_in<=req_data at edge k, then HOLD, then DONE. Defaults: done at k+3.
- DONE: one cycle, done=1, req_ready=0. rsp_data was loaded from synchronizer stage 2 at the edge ending the last HOLD cycle. Next state IDLE.
- p_fb and p_in hold their last written values across operations and change only on WRITE/SETIN accept.
- WRITE with req_mask=0 runs the full sequence with no p_en pulse; rsp_data reflects unchanged cells.
- p_en and p_rst are never high simultaneously. p_fb never changes while any p_en=1.
- Phase counter width is clog2(max(SETUP_CYC,EN_CYC,HOLD_CYC,RST_CYC)+1). Each phase lasts exactly its parameter value; no off-by-one.

Test Plan:
- Bench: 8 P-cell models with INIT=0, default parameters.
- Power-up: hold rst_n=0 for 3 cycles, release -> p_rst=1 for exactly 4 cycles, then req_ready=1; done stays 0 throughout.
- WRITE mask=0x0F data=0xA5 accepted at k -> p_fb=0xA5 from k+1, p_en=0x0F only in cycle k+3, done in k+6 with rsp_data=0x05, req_ready=1 in k+7.
- READ after the write -> done at k+3, rsp_data=0x05. Then SETIN data=0xFF -> done at k+3, rsp_data=0xFA, p_in=0xFF held.
- RESET op with p_in=0xFF -> p_rst high 4 cycles, no p_en; done at k+7, rsp_data=0x00. A following SETIN 0x00 -> rsp_data=0xFF.
- Edge cases:
  - WRITE mask=0x00 data=0xFF -> no p_en pulse, rsp_data unchanged.
  - req_valid held high during busy -> exactly one accept per IDLE cycle.
- Drop rst_n in the ENABLE cycle of a WRITE -> p_en=0 and p_rst=1 at the next edge, no done; after release the full 4-cycle init runs.
